// File: rtl/fwd_sel_gen_if.sv
// ID-stage operand-forwarding bus: decoded source/destination info in, mux selects and stall out.
interface fwd_sel_gen_if #(
    parameter int unsigned REG_ADDR_W = 5
);
    logic                  id_valid_i;
    logic [REG_ADDR_W-1:0] id_rs1_addr_i;
    logic [REG_ADDR_W-1:0] id_rs2_addr_i;
    logic                  id_rs1_used_i;
    logic                  id_rs2_used_i;
    logic [REG_ADDR_W-1:0] id_rd_addr_i;
    logic                  id_rd_we_i;
    logic                  id_is_load_i;
    logic                  hold_i;
    logic                  flush_i;
    logic [1:0]            fwd_sel_a_o;
    logic [1:0]            fwd_sel_b_o;
    logic                  stall_o;

    modport master (
        output id_valid_i, id_rs1_addr_i, id_rs2_addr_i, id_rs1_used_i, id_rs2_used_i,
               id_rd_addr_i, id_rd_we_i, id_is_load_i, hold_i, flush_i,
        input  fwd_sel_a_o, fwd_sel_b_o, stall_o
    );

    modport slave (
        input  id_valid_i, id_rs1_addr_i, id_rs2_addr_i, id_rs1_used_i, id_rs2_used_i,
               id_rd_addr_i, id_rd_we_i, id_is_load_i, hold_i, flush_i,
        output fwd_sel_a_o, fwd_sel_b_o, stall_o
    );
endinterface

// File: rtl/fwd_sel_gen.sv
// EX-operand forwarding select generator with load-use stall detection.
// FWD_WB_SEL_EN enables the WB (10) forwarding path; without it MEM-entry matches stall instead.
module fwd_sel_gen #(
    parameter int unsigned REG_ADDR_W = 5
) (
    input logic         clk_i,
    input logic         rst_ni,
    fwd_sel_gen_if.slave bus
);
    localparam logic [1:0] SelRf  = 2'b00;
    localparam logic [1:0] SelMem = 2'b01;
`ifdef FWD_WB_SEL_EN
    localparam logic [1:0] SelWb  = 2'b10;
`endif

    logic                  ex_valid_q, ex_we_q, ex_load_q;
    logic [REG_ADDR_W-1:0] ex_rd_q;
    logic                  mem_valid_q, mem_we_q;
    logic [REG_ADDR_W-1:0] mem_rd_q;
    logic [1:0]            sel_a_q, sel_b_q;

    logic       ex_elig, mem_elig;
    logic       rs1_live, rs2_live;
    logic       ex_hit1, ex_hit2, mem_hit1, mem_hit2;
    logic       hazard, stall, capture;
    logic [1:0] sel_a_d, sel_b_d;

    always_comb begin
        ex_elig  = ex_valid_q  && ex_we_q  && (ex_rd_q  != '0);
        mem_elig = mem_valid_q && mem_we_q && (mem_rd_q != '0);
        rs1_live = bus.id_rs1_used_i && (bus.id_rs1_addr_i != '0);
        rs2_live = bus.id_rs2_used_i && (bus.id_rs2_addr_i != '0);
        ex_hit1  = rs1_live && ex_elig  && (ex_rd_q  == bus.id_rs1_addr_i);
        ex_hit2  = rs2_live && ex_elig  && (ex_rd_q  == bus.id_rs2_addr_i);
        mem_hit1 = rs1_live && mem_elig && (mem_rd_q == bus.id_rs1_addr_i);
        mem_hit2 = rs2_live && mem_elig && (mem_rd_q == bus.id_rs2_addr_i);

        // A load in EX cannot forward; the EX match still shadows any older MEM match.
        hazard = (ex_hit1 || ex_hit2) && ex_load_q;
`ifndef FWD_WB_SEL_EN
        hazard = hazard || (mem_hit1 && !ex_hit1) || (mem_hit2 && !ex_hit2);
`endif
        stall   = bus.id_valid_i && hazard && !bus.flush_i && !bus.hold_i;
        capture = bus.id_valid_i && !stall && !bus.flush_i;

        sel_a_d = SelRf;
        sel_b_d = SelRf;
        if (ex_hit1 && !ex_load_q) begin
            sel_a_d = SelMem;
        end
`ifdef FWD_WB_SEL_EN
        else if (mem_hit1) begin
            sel_a_d = SelWb;
        end
`endif
        if (ex_hit2 && !ex_load_q) begin
            sel_b_d = SelMem;
        end
`ifdef FWD_WB_SEL_EN
        else if (mem_hit2) begin
            sel_b_d = SelWb;
        end
`endif
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ex_valid_q  <= 1'b0;
            ex_we_q     <= 1'b0;
            ex_load_q   <= 1'b0;
            ex_rd_q     <= '0;
            mem_valid_q <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_rd_q    <= '0;
            sel_a_q     <= SelRf;
            sel_b_q     <= SelRf;
        end else if (!bus.hold_i) begin
            mem_valid_q <= ex_valid_q;
            mem_we_q    <= ex_we_q;
            mem_rd_q    <= ex_rd_q;
            if (capture) begin
                ex_valid_q <= 1'b1;
                ex_we_q    <= bus.id_rd_we_i;
                ex_load_q  <= bus.id_is_load_i;
                ex_rd_q    <= bus.id_rd_addr_i;
                sel_a_q    <= sel_a_d;
                sel_b_q    <= sel_b_d;
            end else begin
                ex_valid_q <= 1'b0;
                ex_we_q    <= 1'b0;
                ex_load_q  <= 1'b0;
                ex_rd_q    <= '0;
                sel_a_q    <= SelRf;
                sel_b_q    <= SelRf;
            end
        end
    end

    assign bus.fwd_sel_a_o = sel_a_q;
    assign bus.fwd_sel_b_o = sel_b_q;
    assign bus.stall_o     = stall;
endmodule

// File: doc/fwd_sel_gen.md
# fwd_sel_gen

- Produces the 2-bit select codes that steer the EX-stage operand 3-to-1 muxes: 00 = register file, 01 = MEM-stage result, 10 = WB-stage result.
- Tracks destination registers of in-flight instructions in the EX and MEM stages and compares them against the source registers of the instruction leaving ID.
- Registers the resulting selects so they are valid while that instruction sits in EX.
- Raises a load-use stall when forwarding cannot resolve a hazard.

## Interface
Parameters:
- REG_ADDR_W, 5, register address width.

Ports:
- clk_i  input  1  core clock.
- rst_ni  input  1  asynchronous, active-low reset.
- id_valid_i  input  1  ID holds a valid instruction.
- id_rs1_addr_i / id_rs2_addr_i  input  REG_ADDR_W  source register addresses.
- id_rs1_used_i / id_rs2_used_i  input  1  the source operand is actually read.
- id_rd_addr_i  input  REG_ADDR_W  destination register address.
- id_rd_we_i  input  1  the instruction writes rd.
- id_is_load_i  input  1  the instruction is a load; its result is available only in WB.
- hold_i  input  1  downstream stall; freeze all state.
- flush_i  input  1  kill the ID instruction; do not capture it.
- fwd_sel_a_o  output  2  select for the operand-A mux, registered.
- fwd_sel_b_o  output  2  select for the operand-B mux, registered.
- stall_o  output  1  hold IF/ID this cycle; combinational.

## Operation
- Internal state:
  - EX entry: {valid, rd, we, load}.
  - MEM entry: {valid, rd, we}.
  - Two select registers.
- A producer is eligible only if its entry is valid, we=1 and rd!=0. Register x0 is never forwarded.
- Operand select, computed for rsN when rsN_used=1 and rsN!=0:
  - Eligible EX entry with rd==rsN and load=0 -> 01. That instruction is in MEM next cycle.
  - Otherwise, eligible MEM entry with rd==rsN -> 10. That instruction is in WB next cycle.
  - Otherwise -> 00.
  - The youngest producer always wins.
- Load-use hazard: id_valid_i and an eligible EX entry with load=1 and rd equal to a used, non-zero rsN -> stall_o=1.
- stall_o is forced to 0 when flush_i=1 or hold_i=1.
- Clock edge with hold_i=1: nothing changes.
- Clock edge with hold_i=0:
  - MEM <= EX.
  - If id_valid_i && !stall_o && !flush_i: EX <= ID fields and the select registers <= the computed codes.
  - Otherwise: EX <= bubble (valid=0) and selects <= 00.
- Code 11 is never produced.
- The register file writes in WB with write-before-read bypass, so no forwarding from beyond WB is needed.

## Timing
- Reset (rst_ni low, asynchronous): both entries invalid, fwd_sel_a_o=00, fwd_sel_b_o=00; stall_o evaluates to 0.
- Select latency: the codes are computed in the cycle the instruction is in ID and appear on the outputs the cycle it is in EX (1 cycle).
- A load-use hazard costs exactly one bubble: the next cycle the load is in MEM and the consumer gets 10.
- Reset asserted mid-operation discards all entries. The first instruction after release always gets 00.
- rs1==rs2 matching a producer: both selects get the same code.

## Configuration
- Macro FWD_WB_SEL_EN.
- Defined: behaviour as above; code 10 is generated for MEM-entry matches.
- Undefined:
  - No WB forwarding path exists; select 10 is never produced.
  - A MEM-entry match (load or non-load) asserts stall_o for one cycle instead. The consumer then reads the register file (00) after the WB bypass.
  - A load in EX matching a consumer stalls two cycles.

## Test plan
- Reset: drive rst_ni=0 mid-stream with EX and MEM both valid -> selects 00 and stall_o=0 immediately; after release an ADD reading x5 gets 00.
- EX forward: ADD x5 then SUB x6,x5,x7 back-to-back -> the SUB in EX sees fwd_sel_a_o=01, fwd_sel_b_o=00.
- MEM forward and priority:
  - ADD x5, NOP, then OR x8,x5,x5 -> both selects 10.
  - ADD x5, ADD x5, OR x8,x5 -> sel_a=01.
- x0 and unused operands: ADDI x0 followed by a read of x0 -> 00; rs2_used=0 with a matching rs2 -> sel_b=00.
- Load-use: LW x3 then ADD x4,x3,x1 -> stall_o=1 for one cycle, one bubble in EX, then the ADD gets sel_a=10. Without FWD_WB_SEL_EN: two stall cycles, then sel_a=00.
- Hold and flush:
  - hold_i=1 for 3 cycles during a hazard -> selects and entries unchanged and stall_o=0.
  - flush_i=1 -> EX becomes a bubble and the following consumer gets 00.
